traffic_cmd_gen: RTL

TRAFFIC_CMD_GEN -- requirements
Module: traffic_cmd_gen

---
 rtl/traffic_lights_pkg.sv | 29 ++
 rtl/traffic_cmd_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_pkg.sv
// Shared codes for the traffic-light command path: command and op
// encodings plus widths common to the generator and the light controller.
package traffic_lights_pkg;

    localparam int CMD_W          = 3;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_ON           = 3'd0,
        CMD_OFF          = 3'd1,
        CMD_NOTRANSITION = 3'd2,
        CMD_SET_GREEN    = 3'd3,
        CMD_SET_RED      = 3'd4,
        CMD_SET_YELLOW   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        OP_CONFIGURE = 2'd0,
        OP_ON        = 2'd1,
        OP_OFF       = 2'd2,
        OP_STANDBY   = 2'd3
    } op_e;

    // Index of the final command in the sequence an op expands to.
    function automatic logic [2:0] last_idx(input op_e op);
        return (op == OP_CONFIGURE) ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/traffic_cmd_gen.sv
// Expands host requests into paced command strobes for the light controller.
// Define TRAFFIC_CMD_GEN_ZERO_CHECK_EN to reject CONFIGURE with a zero period.
module traffic_cmd_gen
    import traffic_lights_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_green_i,
    input  logic [DATA_W-1:0] req_red_i,
    input  logic [DATA_W-1:0] req_yellow_i,
    output logic              cmd_valid_o,
    output logic [CMD_W-1:0]  cmd_type_o,
    output logic [DATA_W-1:0] cmd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DATA_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [2:0]          idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [DATA_W-1:0]   green_q, green_d;
    logic [DATA_W-1:0]   red_q, red_d;
    logic [DATA_W-1:0]   yellow_q, yellow_d;
    logic                valid_q, valid_d;
    logic [CMD_W-1:0]    type_q, type_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                reject;

    function automatic logic [CMD_W+DATA_W-1:0] cmd_of(
        input op_e               op,
        input logic [2:0]        idx,
        input logic [DATA_W-1:0] g,
        input logic [DATA_W-1:0] r,
        input logic [DATA_W-1:0] y
    );
        cmd_of = '0;
        case (op)
            OP_CONFIGURE: begin
                case (idx)
                    3'd0:    cmd_of = {CMD_NOTRANSITION, ZERO};
                    3'd1:    cmd_of = {CMD_SET_GREEN, g};
                    3'd2:    cmd_of = {CMD_SET_RED, r};
                    3'd3:    cmd_of = {CMD_SET_YELLOW, y};
                    3'd4:    cmd_of = {CMD_ON, ZERO};
                    default: cmd_of = '0;
                endcase
            end
            OP_ON:      cmd_of = {CMD_ON, ZERO};
            OP_OFF:     cmd_of = {CMD_OFF, ZERO};
            OP_STANDBY: cmd_of = {CMD_NOTRANSITION, ZERO};
            default:    cmd_of = '0;
        endcase
    endfunction

`ifdef TRAFFIC_CMD_GEN_ZERO_CHECK_EN
    logic err_q;

    assign reject = (req_op_i == OP_CONFIGURE) &&
                    ((req_green_i == ZERO) ||
                     (req_red_i == ZERO) ||
                     (req_yellow_i == ZERO));

    // Rejected requests are still consumed; only the error strobe results.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_valid_i && (state_q == S_IDLE) && reject;
        end
    end

    assign err_o = err_q;
`else
    assign reject = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        green_d  = green_q;
        red_d    = red_q;
        yellow_d = yellow_q;
        valid_d  = 1'b0;
        type_d   = '0;
        data_d   = '0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i && !reject) begin
                    op_d     = op_e'(req_op_i);
                    green_d  = req_green_i;
                    red_d    = req_red_i;
                    yellow_d = req_yellow_i;
                    idx_d    = 3'd0;
                    state_d  = S_SEND;
                    valid_d  = 1'b1;
                    {type_d, data_d} = cmd_of(op_d, 3'd0, req_green_i,
                                              req_red_i, req_yellow_i);
                end
            end
            S_SEND: begin
                if (idx_q == last_idx(op_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    idx_d   = idx_q + 3'd1;
                    valid_d = 1'b1;
                    {type_d, data_d} = cmd_of(op_q, idx_d, green_q,
                                              red_q, yellow_q);
                end else begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                    idx_d   = idx_q + 3'd1;
                    valid_d = 1'b1;
                    {type_d, data_d} = cmd_of(op_q, idx_d, green_q,
                                              red_q, yellow_q);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_CONFIGURE;
            idx_q    <= '0;
            gap_q    <= '0;
            green_q  <= '0;
            red_q    <= '0;
            yellow_q <= '0;
            valid_q  <= 1'b0;
            type_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            green_q  <= green_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = ~req_ready_o;
    assign cmd_valid_o = valid_q;
    assign cmd_type_o  = type_q;
    assign cmd_data_o  = data_q;
    assign done_o      = done_q;

endmodule
